// File: rtl/spi_pkg.sv
// Shared widths, frame layout and state type for the SPI command slave.
package spi_pkg;

  localparam int unsigned CMD_W      = 8;
  localparam int unsigned TILE_W     = 3;
  localparam int unsigned OP_W       = 3;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FRAME_BITS = 25;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

  localparam int unsigned CMD_LSB    = 17;
  localparam int unsigned TILE_I_LSB = 14;
  localparam int unsigned TILE_J_LSB = 11;
  localparam int unsigned OP_LSB     = 8;
  localparam int unsigned DATA_LSB   = 0;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [TILE_W-1:0] tile_i;
    logic [TILE_W-1:0] tile_j;
    logic [OP_W-1:0]   op_code;
    logic [DATA_W-1:0] data_in;
  } fields_t;

  function automatic fields_t decode_frame(input logic [FRAME_BITS-1:0] frame);
    fields_t f;
    f.cmd     = frame[CMD_LSB    +: CMD_W];
    f.tile_i  = frame[TILE_I_LSB +: TILE_W];
    f.tile_j  = frame[TILE_J_LSB +: TILE_W];
    f.op_code = frame[OP_LSB     +: OP_W];
    f.data_in = frame[DATA_LSB   +: DATA_W];
    return f;
  endfunction

endpackage

// File: rtl/spi_slave_sync_ff.sv
// Single-bit multi-stage synchronizer for asynchronous SPI pins.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Deliberately not reset: flushing the chain on rst would fake a cs_n edge
  // while the host keeps cs_n low through a reset.
  always_ff @(posedge clk) begin
    sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: receives a 25-bit command frame and returns a status byte on miso.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = spi_pkg::FRAME_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  output logic [CMD_W-1:0]  cmd,
  output logic [TILE_W-1:0] tile_i,
  output logic [TILE_W-1:0] tile_j,
  output logic [OP_W-1:0]   op_code,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              valid
);

  logic sclk_s, mosi_s, cs_n_s;
  logic sclk_prev_q, cs_n_prev_q;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .d(sclk), .q(sclk_s));
  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .d(mosi), .q(mosi_s));
  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs_n (.clk(clk), .d(cs_n), .q(cs_n_s));

  // Edge history follows the synchronizers through reset so that a held-low
  // cs_n is never mistaken for a new frame start.
  always_ff @(posedge clk) begin
    sclk_prev_q <= sclk_s;
    cs_n_prev_q <= cs_n_s;
  end

  assign sclk_rise =  sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s &  sclk_prev_q;
  assign cs_fall   = ~cs_n_s &  cs_n_prev_q;
  assign cs_rise   =  cs_n_s & ~cs_n_prev_q;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   rx_q, rx_d, rx_next;
  logic [DATA_W-1:0]       tx_q, tx_d;
  logic                    miso_q, miso_d;
  logic                    valid_q, valid_d;
  fields_t                 fields_q, fields_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    miso_d   = miso_q;
    valid_d  = valid_q;
    fields_d = fields_q;
    rx_next  = {rx_q[FRAME_BITS-2:0], mosi_s};

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          rx_d    = '0;
          valid_d = 1'b0;
          tx_d    = data_out;
          miso_d  = data_out[DATA_W-1];
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          tx_d    = '0;
          miso_d  = 1'b0;
        end else begin
          if (sclk_rise && (cnt_q < CNT_W'(FRAME_BITS))) begin
            rx_d  = rx_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
              fields_d = decode_frame(rx_next);
              valid_d  = 1'b1;
            end
          end
          // Zero fill makes miso drop to 0 once the status byte is exhausted.
          if (sclk_fall) begin
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            miso_d = tx_q[DATA_W-2];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      miso_q   <= 1'b0;
      valid_q  <= 1'b0;
      fields_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      miso_q   <= miso_d;
      valid_q  <= valid_d;
      fields_q <= fields_d;
    end
  end

  assign miso    = miso_q;
  assign valid   = valid_q;
  assign cmd     = fields_q.cmd;
  assign tile_i  = fields_q.tile_i;
  assign tile_j  = fields_q.tile_j;
  assign op_code = fields_q.op_code;
  assign data_in = fields_q.data_in;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: host-side SPI driver with a field-level reference model.
module tb_spi_slave;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned HALF        = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       miso;
  logic [7:0] cmd;
  logic [2:0] tile_i;
  logic [2:0] tile_j;
  logic [2:0] op_code;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid;

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(SYNC_STAGES), .FRAME_BITS(25)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso),
    .cmd(cmd), .tile_i(tile_i), .tile_j(tile_j), .op_code(op_code),
    .data_in(data_in), .data_out(data_out), .valid(valid)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected host-visible field values.
  int unsigned m_cmd, m_ti, m_tj, m_op, m_din;
  bit          m_valid;

  task automatic model_reset();
    m_cmd = 0; m_ti = 0; m_tj = 0; m_op = 0; m_din = 0; m_valid = 0;
  endtask

  function automatic int unsigned pack_fields(input int unsigned c, input int unsigned ti,
                                              input int unsigned tj, input int unsigned op,
                                              input int unsigned d);
    return c * 131072 + ti * 16384 + tj * 2048 + op * 256 + d;
  endfunction

  task automatic model_accept(input int unsigned f);
    m_cmd   = (f / 131072) % 256;
    m_ti    = (f / 16384) % 8;
    m_tj    = (f / 2048) % 8;
    m_op    = (f / 256) % 8;
    m_din   = f % 256;
    m_valid = 1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/cmd"},     32'(cmd),     m_cmd);
    check({tag, "/tile_i"},  32'(tile_i),  m_ti);
    check({tag, "/tile_j"},  32'(tile_j),  m_tj);
    check({tag, "/op_code"}, 32'(op_code), m_op);
    check({tag, "/data_in"}, 32'(data_in), m_din);
    check({tag, "/valid"},   32'(valid),   32'(m_valid));
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Clocks nbits bits of frame f (MSB first, extras beyond 25 are 1s or random)
  // and checks miso against status byte dout before each rising edge.
  task automatic shift_bits(input string tag, input int unsigned f, input int unsigned nbits,
                            input bit rand_extra, input logic [7:0] dout);
    int unsigned exp_miso;
    for (int unsigned i = 0; i < nbits; i++) begin
      if (i < 25) mosi = 1'(f >> (24 - i));
      else        mosi = rand_extra ? 1'($urandom_range(0, 1)) : 1'b1;
      wait_clk(HALF);
      exp_miso = (i < 8) ? 32'((dout >> (7 - i)) & 8'h01) : 0;
      check({tag, "/miso"}, 32'(miso), exp_miso);
      sclk = 1'b1;
      if (i == 24) begin
        wait_clk(SYNC_STAGES + 2);
        model_accept(f);
        check_outputs({tag, "/latency"});
        wait_clk(HALF - (SYNC_STAGES + 2));
      end else begin
        wait_clk(HALF);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input string tag, input int unsigned f, input int unsigned nbits,
                            input bit rand_extra, input logic [7:0] dout);
    data_out = dout;
    cs_n     = 1'b0;
    m_valid  = 0;
    wait_clk(4 * HALF);
    check({tag, "/valid_clr"}, 32'(valid), 0);
    shift_bits(tag, f, nbits, rand_extra, dout);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(2 * HALF);
    check_outputs(tag);
    check({tag, "/miso_idle"}, 32'(miso), 0);
  endtask

  int unsigned f_nom, f_b2b;

  initial begin
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; data_out = 8'h00;
    model_reset();
    wait_clk(6);
    check_outputs("reset");
    check("reset/miso", 32'(miso), 0);
    rst = 1'b0;
    wait_clk(4);
    check_outputs("post_reset");

    f_nom = pack_fields(8'h01, 1, 2, 3, 8'hAA);
    send_frame("nominal", f_nom, 25, 1'b0, 8'h55);

    send_frame("short", pack_fields(8'h7E, 6, 5, 4, 8'h11), 24, 1'b0, 8'hC3);

    f_b2b = pack_fields(8'hFF, 7, 0, 5, 8'h3C);
    send_frame("b2b_a", f_b2b, 25, 1'b0, 8'hA5);
    send_frame("b2b_b", f_nom, 25, 1'b0, 8'hA5);

    send_frame("overlong", f_nom, 30, 1'b0, 8'h55);

    // Reset mid-frame with cs_n held low: later sclk pulses must be ignored.
    data_out = 8'h96;
    cs_n     = 1'b0;
    wait_clk(4 * HALF);
    shift_bits("midrst_pre", f_b2b, 10, 1'b0, 8'h96);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    model_reset();
    wait_clk(1);
    check_outputs("midrst");
    check("midrst/miso", 32'(miso), 0);
    shift_bits("midrst_post", f_b2b, 20, 1'b0, 8'h00);
    check_outputs("midrst_ignored");
    cs_n = 1'b1;
    wait_clk(2 * HALF);
    send_frame("fresh", f_nom, 25, 1'b0, 8'h55);

    // Idle noise on sclk/mosi with cs_n high.
    for (int unsigned k = 0; k < 12; k++) begin
      mosi = 1'($urandom_range(0, 1));
      sclk = ~sclk;
      wait_clk(HALF);
    end
    sclk = 1'b0;
    wait_clk(HALF);
    check_outputs("idle_noise");
    check("idle_noise/miso", 32'(miso), 0);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    model_reset();
    wait_clk(1);
    check_outputs("idle_rst");
    check("idle_rst/miso", 32'(miso), 0);

    for (int unsigned r = 0; r < 20; r++) begin
      int unsigned nb;
      int unsigned sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       nb = $urandom_range(1, 24);
        1:       nb = 24;
        2:       nb = 25;
        default: nb = $urandom_range(26, 30);
      endcase
      send_frame($sformatf("rand%0d_n%0d", r, nb),
                 pack_fields($urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 7),
                             $urandom_range(0, 7), $urandom_range(0, 255)),
                 nb, 1'b1, 8'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
